mem_access_stage: RTL and testbench

- Memory-access pipe stage; sits directly downstream of the execute stage and consumes its registered result (ALU value or effective address) and store data.
- Loads and stores drive a request/grant/response data-memory port with byte-lane steering and load sign/zero extension.
- Non-memory results pass through to writeback.
- Upstream is stalled via mem_hold while an access is in flight.

---
 rtl/mem_access_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_stage.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipe stage: drives the data-memory request/grant/response port for loads/stores
// and passes ALU results through to writeback. Optional misalignment trap via MISALIGN_TRAP_EN.
module mem_access_stage #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic            mem_en,
   input  logic [3:0]      mem_op,
   input  logic [XLEN-1:0] exe_result,
   input  logic [XLEN-1:0] store_src,
   input  logic [4:0]      rd_in,
   output logic            mem_hold,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [3:0]      dmem_be,
   output logic [XLEN-1:0] dmem_wdata,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic [XLEN-1:0] wb_data,
   output logic [4:0]      wb_rd,
   output logic            bus_err,
   output logic            misaligned_exc
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t           state;
   logic [CNT_W-1:0] tmo_cnt;
   logic [1:0]       lat_off;
   logic [2:0]       lat_op;
   logic [4:0]       lat_rd;

   logic [3:0]       be_c;
   logic [XLEN-1:0]  wdata_c;
   logic             misaligned_c;
   logic [15:0]      lane_c;
   logic [XLEN-1:0]  load_c;
   logic             timeout_c;

   assign mem_hold  = (state != IDLE);
   assign timeout_c = (tmo_cnt == CNT_W'(TIMEOUT - 1));

   // Byte-lane steering for the outgoing request
   always_comb begin
      be_c    = 4'b1111;
      wdata_c = store_src;
      case (mem_op[1:0])
         2'b00: begin
            be_c    = 4'b0001 << exe_result[1:0];
            wdata_c = XLEN'({4{store_src[7:0]}});
         end
         2'b01: begin
            be_c    = 4'b0011 << {exe_result[1], 1'b0};
            wdata_c = XLEN'({2{store_src[15:0]}});
         end
         default: begin
            be_c    = 4'b1111;
            wdata_c = store_src;
         end
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   assign misaligned_c = ((mem_op[1:0] == 2'b01) && exe_result[0]) ||
                         (mem_op[1] && (exe_result[1:0] != 2'b00));
`else
   assign misaligned_c = 1'b0;
`endif

   // Lane select and sign/zero extension of returning load data
   assign lane_c = 16'(dmem_rdata >> {lat_off, 3'b000});

   always_comb begin
      load_c = dmem_rdata;
      case (lat_op[1:0])
         2'b00:   load_c = lat_op[2] ? XLEN'(lane_c[7:0])
                                     : {{(XLEN-8){lane_c[7]}}, lane_c[7:0]};
         2'b01:   load_c = lat_op[2] ? XLEN'(lane_c)
                                     : {{(XLEN-16){lane_c[15]}}, lane_c};
         default: load_c = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         tmo_cnt        <= '0;
         lat_off        <= '0;
         lat_op         <= '0;
         lat_rd         <= '0;
         dmem_req       <= 1'b0;
         dmem_we        <= 1'b0;
         dmem_addr      <= '0;
         dmem_be        <= '0;
         dmem_wdata     <= '0;
         wb_valid       <= 1'b0;
         wb_data        <= '0;
         wb_rd          <= '0;
         bus_err        <= 1'b0;
         misaligned_exc <= 1'b0;
      end else begin
         wb_valid       <= 1'b0;
         bus_err        <= 1'b0;
         misaligned_exc <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (!mem_en) begin
                     wb_valid <= 1'b1;
                     wb_data  <= exe_result;
                     wb_rd    <= rd_in;
                  end else if (misaligned_c) begin
                     wb_valid       <= 1'b1;
                     wb_data        <= exe_result;
                     wb_rd          <= '0;
                     misaligned_exc <= 1'b1;
                  end else begin
                     dmem_req   <= 1'b1;
                     dmem_we    <= mem_op[3];
                     dmem_addr  <= {exe_result[XLEN-1:2], 2'b00};
                     dmem_be    <= be_c;
                     dmem_wdata <= wdata_c;
                     lat_off    <= exe_result[1:0];
                     lat_op     <= mem_op[2:0];
                     lat_rd     <= rd_in;
                     tmo_cnt    <= '0;
                     state      <= REQ;
                  end
               end
            end
            REQ: begin
               tmo_cnt <= tmo_cnt + CNT_W'(1);
               if (timeout_c) begin
                  dmem_req <= 1'b0;
                  bus_err  <= 1'b1;
                  wb_valid <= 1'b1;
                  wb_data  <= '0;
                  wb_rd    <= lat_rd;
                  state    <= IDLE;
               end else if (dmem_gnt) begin
                  dmem_req <= 1'b0;
                  if (dmem_we) begin
                     wb_valid <= 1'b1;
                     wb_data  <= '0;
                     wb_rd    <= '0;
                     state    <= IDLE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               tmo_cnt <= tmo_cnt + CNT_W'(1);
               if (timeout_c) begin
                  bus_err  <= 1'b1;
                  wb_valid <= 1'b1;
                  wb_data  <= '0;
                  wb_rd    <= lat_rd;
                  state    <= IDLE;
               end else if (dmem_rvalid) begin
                  wb_valid <= 1'b1;
                  wb_data  <= load_c;
                  wb_rd    <= lat_rd;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (TIMEOUT=4): pass-through, stores, loads,
// gnt/rvalid overlap, timeout and asynchronous reset mid-access.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        mem_en;
   logic [3:0]  mem_op;
   logic [31:0] exe_result;
   logic [31:0] store_src;
   logic [4:0]  rd_in;
   logic        mem_hold;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_rd;
   logic        bus_err;
   logic        misaligned_exc;

   int n_chk  = 0;
   int n_fail = 0;

   mem_access_stage #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .mem_en         (mem_en),
      .mem_op         (mem_op),
      .exe_result     (exe_result),
      .store_src      (store_src),
      .rd_in          (rd_in),
      .mem_hold       (mem_hold),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_be        (dmem_be),
      .dmem_wdata     (dmem_wdata),
      .dmem_gnt       (dmem_gnt),
      .dmem_rvalid    (dmem_rvalid),
      .dmem_rdata     (dmem_rdata),
      .wb_valid       (wb_valid),
      .wb_data        (wb_data),
      .wb_rd          (wb_rd),
      .bus_err        (bus_err),
      .misaligned_exc (misaligned_exc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [4:0] rd);
      in_valid   = 1'b1;
      mem_en     = 1'b1;
      mem_op     = op;
      exe_result = addr;
      store_src  = sdata;
      rd_in      = rd;
   endtask

   initial begin
      rst = 1'b0; in_valid = 1'b0; mem_en = 1'b0; mem_op = '0; exe_result = '0;
      store_src = '0; rd_in = '0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_req",   32'(dmem_req), 32'd0);
      chk("rst_hold",  32'(mem_hold), 32'd0);
      chk("rst_wbv",   32'(wb_valid), 32'd0);
      chk("rst_wbd",   wb_data,       32'd0);
      chk("rst_berr",  32'(bus_err),  32'd0);
      rst = 1'b1;

      // Pass-through
      @(negedge clk);
      in_valid = 1'b1; mem_en = 1'b0; exe_result = 32'h1234_5678; rd_in = 5'd5;
      @(negedge clk);
      chk("pt_wbv",  32'(wb_valid), 32'd1);
      chk("pt_wbd",  wb_data,       32'h1234_5678);
      chk("pt_wbrd", 32'(wb_rd),    32'd5);
      chk("pt_hold", 32'(mem_hold), 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("pt_wbv_off", 32'(wb_valid), 32'd0);

      // Store byte, grant after 3 cycles
      issue(4'b1000, 32'h0000_1003, 32'h0000_00AB, 5'd7);
      @(negedge clk);
      in_valid = 1'b0;
      chk("sb_req0",  32'(dmem_req), 32'd1);
      chk("sb_we",    32'(dmem_we),  32'd1);
      chk("sb_be",    32'(dmem_be),  32'h8);
      chk("sb_wdata", dmem_wdata,    32'hABAB_ABAB);
      chk("sb_addr",  dmem_addr,     32'h0000_1000);
      chk("sb_hold",  32'(mem_hold), 32'd1);
      @(negedge clk);
      chk("sb_req1",  32'(dmem_req), 32'd1);
      chk("sb_be1",   32'(dmem_be),  32'h8);
      @(negedge clk);
      chk("sb_req2",  32'(dmem_req), 32'd1);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("sb_req_drop", 32'(dmem_req), 32'd0);
      chk("sb_wbv",      32'(wb_valid), 32'd1);
      chk("sb_wbrd",     32'(wb_rd),    32'd0);
      chk("sb_wbd",      wb_data,       32'd0);
      chk("sb_hold_off", 32'(mem_hold), 32'd0);

      // Store half to upper lanes
      issue(4'b1001, 32'h0000_0A06, 32'h1111_BEEF, 5'd2);
      @(negedge clk);
      in_valid = 1'b0;
      chk("sh_be",    32'(dmem_be), 32'hC);
      chk("sh_wdata", dmem_wdata,   32'hBEEF_BEEF);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("sh_wbv", 32'(wb_valid), 32'd1);

      // Load half signed
      issue(4'b0001, 32'h0000_2002, 32'h0, 5'd9);
      @(negedge clk);
      in_valid = 1'b0;
      chk("lh_req",  32'(dmem_req), 32'd1);
      chk("lh_we",   32'(dmem_we),  32'd0);
      chk("lh_be",   32'(dmem_be),  32'hC);
      chk("lh_addr", dmem_addr,     32'h0000_2000);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("lh_wait_req",  32'(dmem_req), 32'd0);
      chk("lh_wait_hold", 32'(mem_hold), 32'd1);
      chk("lh_wait_wbv",  32'(wb_valid), 32'd0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("lh_wbv",  32'(wb_valid), 32'd1);
      chk("lh_wbd",  wb_data,       32'hFFFF_8001);
      chk("lh_wbrd", 32'(wb_rd),    32'd9);
      chk("lh_hold", 32'(mem_hold), 32'd0);

      // Load half unsigned
      issue(4'b0101, 32'h0000_2002, 32'h0, 5'd10);
      @(negedge clk);
      in_valid = 1'b0;
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h8001_0000;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("lhu_wbd",  wb_data,    32'h0000_8001);
      chk("lhu_wbrd", 32'(wb_rd), 32'd10);

      // Load byte signed from lane 1
      issue(4'b0000, 32'h0000_3001, 32'h0, 5'd12);
      @(negedge clk);
      in_valid = 1'b0;
      chk("lb_be", 32'(dmem_be), 32'h2);
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_F256;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("lb_wbd", wb_data, 32'hFFFF_FFF2);

      // Grant and rvalid together in REQ: rvalid ignored
      issue(4'b0010, 32'h0000_4000, 32'h0, 5'd3);
      @(negedge clk);
      in_valid = 1'b0;
      chk("ov_be", 32'(dmem_be), 32'hF);
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
      chk("ov_hold1", 32'(mem_hold), 32'd1);
      chk("ov_wbv1",  32'(wb_valid), 32'd0);
      @(negedge clk);
      chk("ov_hold2", 32'(mem_hold), 32'd1);
      chk("ov_wbv2",  32'(wb_valid), 32'd0);
      dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("ov_wbv",  32'(wb_valid), 32'd1);
      chk("ov_wbd",  wb_data,       32'hCAFE_F00D);
      chk("ov_wbrd", 32'(wb_rd),    32'd3);

      // Timeout with no grant
      issue(4'b0010, 32'h0000_5000, 32'h0, 5'd11);
      @(negedge clk);
      in_valid = 1'b0;
      chk("to_req0", 32'(dmem_req), 32'd1);
      repeat (3) @(negedge clk);
      chk("to_req3",  32'(dmem_req), 32'd1);
      chk("to_berr3", 32'(bus_err),  32'd0);
      @(negedge clk);
      chk("to_berr",  32'(bus_err),  32'd1);
      chk("to_wbv",   32'(wb_valid), 32'd1);
      chk("to_wbd",   wb_data,       32'd0);
      chk("to_wbrd",  32'(wb_rd),    32'd11);
      chk("to_hold",  32'(mem_hold), 32'd0);
      chk("to_req",   32'(dmem_req), 32'd0);
      @(negedge clk);
      chk("to_berr_off", 32'(bus_err), 32'd0);

      // Async reset during REQ drops dmem_req at once
      issue(4'b0010, 32'h0000_6000, 32'h0, 5'd4);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("ar_req",  32'(dmem_req), 32'd0);
      chk("ar_hold", 32'(mem_hold), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Async reset during WAIT: later rvalid owes nothing
      issue(4'b0010, 32'h0000_6004, 32'h0, 5'd4);
      @(negedge clk);
      in_valid = 1'b0;
      dmem_gnt = 1'b1;
      @(negedge clk);
      dmem_gnt = 1'b0;
      chk("aw_hold_pre", 32'(mem_hold), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("aw_hold", 32'(mem_hold), 32'd0);
      chk("aw_req",  32'(dmem_req), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      dmem_rvalid = 1'b0;
      chk("aw_wbv0",  32'(wb_valid), 32'd0);
      chk("aw_hold0", 32'(mem_hold), 32'd0);
      @(negedge clk);
      chk("aw_wbv1",  32'(wb_valid), 32'd0);
      chk("aw_mis",   32'(misaligned_exc), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
